imem_fetch_sequencer: RTL and testbench
=======================================

// Module: imem_fetch_sequencer
// PURPOSE
//  Fetch controller for the byte-wide (8-bit), little-endian instruction memory array.
//  Reads one byte per cycle from the memory's combinational read port and assembles a
//  32-bit instruction plus its PC. Presents them to decode over a valid/ready handshake.
//  Also shares the memory's single port with a program-loader byte-write port.
//  Handles redirects (branch/jump targets) and out-of-range fetch faults.
// PARAMETERS
//  DEPTH     148   number of bytes in instruction memory; valid byte addresses 0..DEPTH-1
//  RESET_PC  0     PC loaded on reset (must be 4-aligned)
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   synchronous, active-high reset
//  redirect_valid  in   1   load new fetch PC this cycle
//  redirect_pc     in   64  new PC; bits [1:0] are ignored (forced to 0)
//  inst_valid      out  1   inst_data/inst_pc hold a complete instruction
//  inst_ready      in   1   decode accepts the instruction
//  inst_data       out  32  {byte3,byte2,byte1,byte0} read at inst_pc+3..inst_pc
//  inst_pc         out  64  address of inst_data
//  fault           out  1   fetch address out of range; fetch is halted
//  load_valid      in   1   loader requests a byte write
//  load_addr       in   64  loader byte address
//  load_data       in   8   loader byte
//  load_ready      out  1   loader write performed this cycle
//  mem_addr        out  64  byte address to memory (read or write)
//  mem_rdata       in   8   combinational byte read data (same cycle as mem_addr)
//  mem_we          out  1   write strobe
//  mem_wdata       out  8   write data (= load_data)
// BEHAVIOUR
//  - Reset (sync, priority over everything):
//    - state=FETCH, pc=RESET_PC, byte_cnt=0.
//    - inst_valid=0, inst_data=0, inst_pc=RESET_PC, fault=0.
//    - mem_we=0 and load_ready=0 while reset is high.
//  - States: FETCH, HOLD, FAULT.
//  - FETCH:
//    - If pc+3 > DEPTH-1, go to FAULT next cycle; no read is issued.
//    - Otherwise mem_addr=pc+byte_cnt. At the clock edge, mem_rdata is captured into
//      byte lane byte_cnt and byte_cnt increments.
//    - After capturing lane 3: go to HOLD, inst_valid=1, inst_pc=pc.
//  - HOLD:
//    - inst_valid=1; inst_data and inst_pc stay stable until transfer.
//    - Transfer = inst_valid & inst_ready at an edge. On transfer: pc+=4, byte_cnt=0,
//      state=FETCH, inst_valid=0.
//  - FAULT:
//    - fault=1, inst_valid=0.
//    - Left only via redirect (to FETCH, fault=0) or reset.
//  - Latency and throughput:
//    - First inst_valid is high 4 cycles after reset is released.
//    - With inst_ready held at 1: one instruction per 5 cycles.
//  - Loader (combinational arbitration; loader has priority in every state):
//    - load_ready = load_valid & ~reset. Then mem_we=1, mem_addr=load_addr, mem_wdata=load_data.
//    - A fetch read is stalled that cycle: byte_cnt does not advance and nothing is captured.
//    - load_addr >= DEPTH: the write is still acknowledged (load_ready=1) and the memory
//      ignores it.
//    - Write to pc..pc+3 while in FETCH or HOLD: the word is discarded. byte_cnt=0,
//      inst_valid=0, state=FETCH (refetch of the same pc).
//  - Redirect (evaluated after loader, before handshake):
//    - Next cycle: pc=redirect_pc & ~3, byte_cnt=0, state=FETCH, inst_valid=0, fault=0.
//    - Redirect together with a transfer: the transfer completes (decode keeps the word)
//      and redirect_pc wins over pc+4.
//    - Redirect together with a load hitting the current word: the redirect wins.
//  - Address arithmetic is 64-bit, wrap-around modulo 2^64. An overflow of pc+3 counts as
//    out of range.
// TESTING
//  - Memory bytes 0..3 = 13 05 00 00, reset 1 cycle, inst_ready=1 -> inst_valid rises 4
//    cycles after reset release; inst_data=0x00000513, inst_pc=0; next word has inst_pc=4.
//  - inst_ready=0 for 10 cycles -> inst_valid held at 1, inst_data/inst_pc stable,
//    mem_addr static, no further reads.
//  - Redirect to 0x8A (misaligned) during byte 2 of a fetch -> next fetch starts at 0x88;
//    the partial word is never presented.
//  - DEPTH=148, redirect to 144 -> word 144 is delivered. Next pc=148 -> fault=1,
//    inst_valid=0. Redirect to 0 -> fault clears and fetch resumes.
//  - load_valid on byte 1 write to pc+1 mid-fetch -> load_ready=1, mem_we=1. The fetch
//    restarts at the same pc and the delivered word contains the new byte.
//  - reset asserted while in HOLD with a load pending -> next cycle inst_valid=0,
//    load_ready=0 during reset, pc=RESET_PC.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// imem_fetch_sequencer
//
// Fetch controller for a byte-wide, little-endian instruction memory. One byte
// is read per cycle from the memory's combinational read port. Four bytes are
// assembled into a 32-bit instruction, which is offered to decode together with
// its PC over a valid/ready handshake. The single memory port is shared with a
// program-loader byte-write port. The loader always wins arbitration.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   redirect_valid   load redirect_pc (4-aligned) as the new fetch PC
//   redirect_pc      64-bit redirect target; bits [1:0] are ignored
//   inst_valid       inst_data / inst_pc hold a complete instruction
//   inst_ready       decode accepts the instruction
//   inst_data        {byte3,byte2,byte1,byte0} read from inst_pc+3..inst_pc
//   inst_pc          address of inst_data
//   fault            fetch PC is out of range; fetch halted until redirect
//   load_valid       loader byte-write request
//   load_addr        loader byte address
//   load_data        loader byte
//   load_ready       loader write performed this cycle
//   mem_addr         byte address to memory (read or write)
//   mem_rdata        combinational read data for mem_addr
//   mem_we           memory write strobe
//   mem_wdata        memory write data
// -----------------------------------------------------------------------------
module imem_fetch_sequencer #(
  parameter int unsigned DEPTH    = 148,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [63:0] inst_pc,
  output logic        fault,
  input  logic        load_valid,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_FAULT
  } state_e;

  localparam logic [63:0] LAST_ADDR = 64'(DEPTH) - 64'd1;

  state_e      state_q,    state_d;
  logic [63:0] pc_q,       pc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q,     word_d;
  logic [63:0] inst_pc_q,  inst_pc_d;

  // Address bits [1:0] of a redirect are dropped by construction.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Loader grant: blocked only while reset is held.
  logic load_go;
  assign load_go = load_valid & ~reset;

  // Last byte of the current word, computed with a carry bit so that a
  // wrap past 2^64 is treated as out of range rather than aliasing low.
  logic [64:0] last_byte;
  logic        out_of_range;
  assign last_byte    = {1'b0, pc_q} + 65'd3;
  assign out_of_range = last_byte[64] | (last_byte[63:0] > LAST_ADDR);

  // A load overlaps the word being fetched/held when it lands in pc..pc+3.
  // The subtraction is modulo 2^64, so only the four bytes at and above pc
  // produce an offset below 4.
  logic [63:0] load_off;
  logic        load_hit;
  assign load_off = load_addr - pc_q;
  assign load_hit = load_go & (load_off < 64'd4) & (state_q != S_FAULT);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      byte_cnt_q <= '0;
      word_q     <= '0;
      inst_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      inst_pc_q  <= inst_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: loader, then redirect, then handshake.
  // The redirect block is applied last so it overrides anything the per-state
  // logic decided, including a load hit or a pc+4 advance.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    inst_pc_d  = inst_pc_q;

    unique case (state_q)
      S_FETCH: begin
        if (load_go) begin
          // Port is busy with the write: no read this cycle. A write into
          // the word under construction restarts it from byte 0.
          if (load_hit) begin
            byte_cnt_d = '0;
          end
        end else if (out_of_range) begin
          state_d = S_FAULT;
        end else begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = mem_rdata;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d   = S_HOLD;
            inst_pc_d = pc_q;
          end
        end
      end

      S_HOLD: begin
        if (load_hit) begin
          // Held word is stale: drop it and refetch the same pc.
          state_d    = S_FETCH;
          byte_cnt_d = '0;
        end else if (inst_ready) begin
          state_d    = S_FETCH;
          pc_d       = pc_q + 64'd4;
          byte_cnt_d = '0;
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: begin
        state_d    = S_FETCH;
        byte_cnt_d = '0;
      end
    endcase

    if (redirect_valid) begin
      state_d    = S_FETCH;
      pc_d       = {redirect_pc[63:2], 2'b00};
      byte_cnt_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_valid = (state_q == S_HOLD);
    fault      = (state_q == S_FAULT);
    inst_data  = word_q;
    inst_pc    = inst_pc_q;
    load_ready = load_go;
    mem_we     = load_go;
    mem_wdata  = load_data;
    mem_addr   = load_go ? load_addr : (pc_q + {62'd0, byte_cnt_q});
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_sequencer
//
// Bench for imem_fetch_sequencer with a 148-byte behavioural memory.
// Memory contents: bytes 0..3 = 13 05 00 00, byte i = i for i >= 4.
// A table of per-cycle vectors covers reset, streaming, backpressure,
// misaligned redirect, end-of-memory fault, and a mid-fetch loader write.
// Hand-written sequences cover latency/throughput counting, reset during
// HOLD with a pending load, and a fault on a PC near 2^64.
// -----------------------------------------------------------------------------
module tb_imem_fetch_sequencer;

  localparam int unsigned DEPTH = 148;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        fault;
  logic        load_valid;
  logic [63:0] load_addr;
  logic [7:0]  load_data;
  logic        load_ready;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wdata;

  always #5 clk = ~clk;

  imem_fetch_sequencer #(.DEPTH(DEPTH), .RESET_PC(64'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fault          (fault),
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_ready     (load_ready),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata)
  );

  // Behavioural memory: initialised on the first clock edge, then written
  // by mem_we for in-range addresses only.
  logic [7:0] mem [0:DEPTH-1];
  logic       mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'(i);
      mem[0] <= 8'h13;
      mem[1] <= 8'h05;
      mem[2] <= 8'h00;
      mem[3] <= 8'h00;
      mem_init_done <= 1'b1;
    end else if (mem_we && mem_addr < 64'(DEPTH)) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  always_comb begin
    if (mem_addr < 64'(DEPTH)) mem_rdata = mem[mem_addr[7:0]];
    else                       mem_rdata = 8'h00;
  end

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [63:0] rdpc;
    logic        rdy;
    logic        ldv;
    logic [63:0] lda;
    logic [7:0]  ldd;
    logic        e_valid;
    logic        e_fault;
    logic        e_lrdy;
    logic        e_we;
    logic [63:0] e_addr;
    logic        chk_word;
    logic [31:0] e_data;
    logic [63:0] e_pc;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic vec_t mk(
    input logic rst, input logic rdv, input logic [63:0] rdpc, input logic rdy,
    input logic ldv, input logic [63:0] lda, input logic [7:0] ldd,
    input logic e_valid, input logic e_fault, input logic e_lrdy, input logic e_we,
    input logic [63:0] e_addr, input logic chk_word, input logic [31:0] e_data,
    input logic [63:0] e_pc);
    vec_t v;
    v.rst = rst; v.rdv = rdv; v.rdpc = rdpc; v.rdy = rdy;
    v.ldv = ldv; v.lda = lda; v.ldd = ldd;
    v.e_valid = e_valid; v.e_fault = e_fault; v.e_lrdy = e_lrdy; v.e_we = e_we;
    v.e_addr = e_addr; v.chk_word = chk_word; v.e_data = e_data; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset          = v.rst;
    redirect_valid = v.rdv;
    redirect_pc    = v.rdpc;
    inst_ready     = v.rdy;
    load_valid     = v.ldv;
    load_addr      = v.lda;
    load_data      = v.ldd;
  endtask

  task automatic idle_fetch(input logic [63:0] addr);
    tbl.push_back(mk(0,0,0,1, 0,0,0, 0,0,0,0, addr, 0, 0, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic ok;

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    load_valid = 1'b0; load_addr = '0; load_data = '0;

    // --- vector table: one row per cycle, inputs set at negedge ---
    // V0: reset state
    tbl.push_back(mk(1,0,0,1, 0,0,0, 0,0,0,0, 64'd0, 1, 32'h0, 64'd0));
    // V1-4: first word bytes 0..3
    for (int a = 0; a < 4; a++) idle_fetch(64'(a));
    // V5: first word presented 4 cycles after release, accepted
    tbl.push_back(mk(0,0,0,1, 0,0,0, 1,0,0,0, 64'd0, 1, 32'h0000_0513, 64'd0));
    // V6-9: second word bytes
    for (int a = 4; a < 8; a++) idle_fetch(64'(a));
    // V10-19: backpressure, everything stable
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0,0,0,0, 0,0,0, 1,0,0,0, 64'd4, 1, 32'h0706_0504, 64'd4));
    // V20: accept
    tbl.push_back(mk(0,0,0,1, 0,0,0, 1,0,0,0, 64'd4, 1, 32'h0706_0504, 64'd4));
    // V21-22: bytes 0,1 of word 8
    idle_fetch(64'd8);
    idle_fetch(64'd9);
    // V23: misaligned redirect during byte 2
    tbl.push_back(mk(0,1,64'h8A,1, 0,0,0, 0,0,0,0, 64'hA, 0, 0, 0));
    // V24-27: refetch from 0x88
    for (int a = 'h88; a < 'h8C; a++) idle_fetch(64'(a));
    // V28: transfer together with redirect to 144
    tbl.push_back(mk(0,1,64'd144,1, 0,0,0, 1,0,0,0, 64'h88, 1, 32'h8B8A_8988, 64'h88));
    // V29-32: last word of memory
    for (int a = 144; a < 148; a++) idle_fetch(64'(a));
    // V33: word 144 delivered
    tbl.push_back(mk(0,0,0,1, 0,0,0, 1,0,0,0, 64'd144, 1, 32'h9392_9190, 64'd144));
    // V34: pc=148 out of range, fault next cycle
    tbl.push_back(mk(0,0,0,1, 0,0,0, 0,0,0,0, 64'd148, 0, 0, 0));
    // V35: fault
    tbl.push_back(mk(0,0,0,1, 0,0,0, 0,1,0,0, 64'd148, 0, 0, 0));
    // V36: fault, redirect to 0
    tbl.push_back(mk(0,1,64'd0,1, 0,0,0, 0,1,0,0, 64'd148, 0, 0, 0));
    // V37: fetch resumes at 0
    idle_fetch(64'd0);
    // V38: loader writes byte 1 mid-fetch
    tbl.push_back(mk(0,0,0,1, 1,64'd1,8'hAA, 0,0,1,1, 64'd1, 0, 0, 0));
    // V39-42: refetch of word 0
    for (int a = 0; a < 4; a++) idle_fetch(64'(a));
    // V43: new byte visible; out-of-range load acknowledged, word kept
    tbl.push_back(mk(0,0,0,0, 1,64'd200,8'h55, 1,0,1,1, 64'd200, 1, 32'h0000_AA13, 64'd0));
    // V44: reset in HOLD with load pending: load blocked
    tbl.push_back(mk(1,0,0,0, 1,64'h10,8'h77, 1,0,0,0, 64'd0, 1, 32'h0000_AA13, 64'd0));
    // V45: post-reset state
    tbl.push_back(mk(0,0,0,1, 0,0,0, 0,0,0,0, 64'd0, 1, 32'h0, 64'd0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      nvec++;
      ok = (inst_valid === tbl[i].e_valid) && (fault === tbl[i].e_fault) &&
           (load_ready === tbl[i].e_lrdy) && (mem_we === tbl[i].e_we) &&
           (mem_addr === tbl[i].e_addr);
      if (tbl[i].chk_word)
        ok = ok && (inst_data === tbl[i].e_data) && (inst_pc === tbl[i].e_pc);
      if (!ok) begin
        nerr++;
        $display("FAIL vec%0d: got valid=%b fault=%b lrdy=%b we=%b addr=%0h data=%0h pc=%0h expected valid=%b fault=%b lrdy=%b we=%b addr=%0h data=%0h pc=%0h",
                 i, inst_valid, fault, load_ready, mem_we, mem_addr, inst_data, inst_pc,
                 tbl[i].e_valid, tbl[i].e_fault, tbl[i].e_lrdy, tbl[i].e_we,
                 tbl[i].e_addr, tbl[i].e_data, tbl[i].e_pc);
      end
    end
    chk("mem_oor_load_ignored_byte16", 64'(mem[16]), 64'h10);

    // --- latency and throughput from a fresh reset ---
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; load_valid = 1'b0; inst_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    cyc = 0;
    while (inst_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk("first_latency", 64'(cyc), 64'd4);
    chk("first_pc", inst_pc, 64'd0);
    chk("first_data", 64'(inst_data), 64'h0000_AA13);

    @(negedge clk); #1; cyc = 1;
    while (inst_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    chk("throughput", 64'(cyc), 64'd5);
    chk("second_pc", inst_pc, 64'd4);
    chk("second_data", 64'(inst_data), 64'h0706_0504);

    // --- reset while holding word 4 with a load into that word pending ---
    inst_ready = 1'b0; reset = 1'b1;
    load_valid = 1'b1; load_addr = 64'd4; load_data = 8'hEE;
    #1;
    chk("rst_load_ready", 64'(load_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0;
    #1;
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_byte4", 64'(mem[4]), 64'd4);

    // --- redirect near the top of the address space faults ---
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("hi_pc_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("hi_pc_nofault_yet", 64'(fault), 64'd0);
    @(negedge clk); #1;
    chk("hi_pc_fault", 64'(fault), 64'd1);
    chk("hi_pc_valid", 64'(inst_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
